// File: rtl/gt_pkg.sv
`default_nettype none
// ============================================================================
// gt_pkg : shared constants and state encoding for the GT RX word aligner
// Rev 1.0
// ============================================================================
package gt_pkg;

    localparam int          c_byte_w = 8;
    localparam int          c_lanes  = 4;
    localparam logic [7:0]  c_k28_5  = 8'hBC;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gt_comma_detect.sv
`default_nettype none
// ============================================================================
// gt_comma_detect : flags a single K-qualified comma lane or a multi-lane hit
// Rev 1.0
// ============================================================================
module gt_comma_detect
    import gt_pkg::*;
#(
    parameter logic [c_byte_w-1:0] P_COMMA = c_k28_5
) (
    input  logic [c_lanes*c_byte_w-1:0] i_data,
    input  logic [c_lanes-1:0]          i_char,
    output logic                        o_hit,
    output logic                        o_multi,
    output logic [1:0]                  o_offset
);

    logic [c_lanes-1:0] w_match;

    generate
        for (genvar g = 0; g < c_lanes; g++) begin : g_lane
            assign w_match[g] = i_char[g] && (i_data[g*c_byte_w +: c_byte_w] == P_COMMA);
        end
    endgenerate

    always_comb begin
        o_hit    = 1'b0;
        o_multi  = 1'b0;
        o_offset = 2'd0;
        case (w_match)
            4'b0000: ;
            4'b0001: begin o_hit = 1'b1; o_offset = 2'd0; end
            4'b0010: begin o_hit = 1'b1; o_offset = 2'd1; end
            4'b0100: begin o_hit = 1'b1; o_offset = 2'd2; end
            4'b1000: begin o_hit = 1'b1; o_offset = 2'd3; end
            default: o_multi = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/gt_rx_word_aligner.sv
`default_nettype none
// ============================================================================
// gt_rx_word_aligner : K28.5 lane search, hunt/check/lock and byte rotation
// Rev 1.0
// ============================================================================
module gt_rx_word_aligner
    import gt_pkg::*;
#(
    parameter logic [7:0] P_COMMA    = c_k28_5,
    parameter int         P_LOCK_CNT = 4,
    parameter int         P_LOSS_CNT = 3,
    parameter int         P_TIMEOUT  = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_byte_align,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_char,
    output logic [31:0] o_data,
    output logic [3:0]  o_char,
    output logic        o_valid,
    output logic        o_locked,
    output logic [1:0]  o_offset,
    output logic [15:0] o_relock_cnt
);

    localparam int c_match_w = $clog2(P_LOCK_CNT + 1);
    localparam int c_miss_w  = $clog2(P_LOSS_CNT + 1);
    localparam int c_tmo_w   = $clog2(P_TIMEOUT + 1);

    localparam logic [c_match_w-1:0] c_match_last = c_match_w'(P_LOCK_CNT - 1);
    localparam logic [c_miss_w-1:0]  c_miss_last  = c_miss_w'(P_LOSS_CNT - 1);
    localparam logic [c_tmo_w-1:0]   c_tmo_last   = c_tmo_w'(P_TIMEOUT - 1);

    logic [31:0]          r_d1;
    logic [3:0]           r_c1;
    state_t               r_state;
    logic [1:0]           r_offset;
    logic [c_match_w-1:0] r_match;
    logic [c_miss_w-1:0]  r_miss;
    logic [c_tmo_w-1:0]   r_tmo;
    logic [15:0]          r_relock;

    logic                 w_hit;
    logic                 w_multi;
    logic [1:0]           w_off;
    logic                 w_aligned;
    logic                 w_lose;
    logic [63:0]          w_stream;
    logic [7:0]           w_cstream;

    gt_comma_detect #(
        .P_COMMA (P_COMMA)
    ) u_detect (
        .i_data   (r_d1),
        .i_char   (r_c1),
        .o_hit    (w_hit),
        .o_multi  (w_multi),
        .o_offset (w_off)
    );

    assign w_aligned = w_hit && (w_off == r_offset);

    // Loss of lock: either the misaligned-comma budget or the comma-free budget runs out.
    always_comb begin
        w_lose = 1'b0;
        if (r_state == ST_LOCK && !w_aligned) begin
            if (w_hit || w_multi) w_lose = (r_miss == c_miss_last);
            else                  w_lose = (r_tmo == c_tmo_last);
        end
    end

    assign w_stream  = {i_data, r_d1};
    assign w_cstream = {i_char, r_c1};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d1   <= '0;
            r_c1   <= '0;
            o_data <= '0;
            o_char <= '0;
        end else begin
            r_d1   <= i_data;
            r_c1   <= i_char;
            o_data <= w_stream[{1'b0, r_offset, 3'b000} +: 32];
            o_char <= w_cstream[{1'b0, r_offset} +: 4];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_HUNT;
            r_offset <= '0;
            r_match  <= '0;
            r_miss   <= '0;
            r_tmo    <= '0;
            r_relock <= '0;
            o_locked <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= (r_state == ST_LOCK) && i_byte_align;
            if (!i_byte_align || w_lose) begin
                r_state  <= ST_HUNT;
                o_locked <= 1'b0;
                r_match  <= '0;
                r_miss   <= '0;
                r_tmo    <= '0;
                if (r_state == ST_LOCK) r_relock <= sat_inc16(r_relock);
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_hit) begin
                            r_offset <= w_off;
                            r_match  <= c_match_w'(1);
                            r_miss   <= '0;
                            r_tmo    <= '0;
                            if (P_LOCK_CNT <= 1) begin
                                r_state  <= ST_LOCK;
                                o_locked <= 1'b1;
                            end else begin
                                r_state  <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (w_multi) begin
                            r_state <= ST_HUNT;
                            r_match <= '0;
                        end else if (w_aligned) begin
                            r_match <= r_match + c_match_w'(1);
                            if (r_match == c_match_last) begin
                                r_state  <= ST_LOCK;
                                o_locked <= 1'b1;
                                r_miss   <= '0;
                                r_tmo    <= '0;
                            end
                        end else if (w_hit) begin
                            r_offset <= w_off;
                            r_match  <= c_match_w'(1);
                        end
                    end
                    ST_LOCK: begin
                        if (w_aligned) begin
                            r_miss <= '0;
                            r_tmo  <= '0;
                        end else if (w_hit || w_multi) begin
                            r_miss <= r_miss + c_miss_w'(1);
                        end else begin
                            r_tmo  <= r_tmo + c_tmo_w'(1);
                        end
                    end
                    default: begin
                        r_state  <= ST_HUNT;
                        o_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_offset     = r_offset;
    assign o_relock_cnt = r_relock;

endmodule
`default_nettype wire

// File: tb/tb_gt_rx_word_aligner.sv
`default_nettype none
// ============================================================================
// tb_gt_rx_word_aligner : vector table, directed sequences and random stream
// Rev 1.0
// ============================================================================
module tb_gt_rx_word_aligner;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int TIMEOUT  = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        ba;
    logic [31:0] din;
    logic [3:0]  cin;
    logic [31:0] o_data;
    logic [3:0]  o_char;
    logic        o_valid;
    logic        o_locked;
    logic [1:0]  o_offset;
    logic [15:0] o_relock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    int          m_mode, m_off, m_match, m_miss, m_tmo, m_relock;
    logic [31:0] m_d1;
    logic [3:0]  m_c1;
    logic [31:0] e_data;
    logic [3:0]  e_char;
    logic        e_valid;
    logic [31:0] prev_d, last_d;

    typedef struct {
        logic        rst;
        logic        ba;
        logic [31:0] d;
        logic [3:0]  c;
        logic [31:0] x_data;
        logic [3:0]  x_char;
        logic        x_valid;
        logic        x_locked;
        logic [1:0]  x_off;
        logic [15:0] x_relock;
    } vec_t;

    vec_t tbl[13];

    gt_rx_word_aligner #(
        .P_COMMA    (8'hBC),
        .P_LOCK_CNT (LOCK_CNT),
        .P_LOSS_CNT (LOSS_CNT),
        .P_TIMEOUT  (TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_byte_align (ba),
        .i_data       (din),
        .i_char       (cin),
        .o_data       (o_data),
        .o_char       (o_char),
        .o_valid      (o_valid),
        .o_locked     (o_locked),
        .o_offset     (o_offset),
        .o_relock_cnt (o_relock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drop_to_hunt();
        if (m_mode == 2 && m_relock < 65535) m_relock++;
        m_mode  = 0;
        m_match = 0;
        m_miss  = 0;
        m_tmo   = 0;
    endtask

    // One rising edge of the reference: rotation window from the 8-byte history,
    // comma classification by lane count, then the hunt/check/lock rules.
    task automatic model_edge(input logic r, input logic b, input logic [31:0] d, input logic [3:0] c);
        int n, k, src;
        if (r) begin
            m_mode = 0; m_off = 0; m_match = 0; m_miss = 0; m_tmo = 0; m_relock = 0;
            m_d1 = '0; m_c1 = '0; e_data = '0; e_char = '0; e_valid = 1'b0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            src = m_off + i;
            if (src < 4) begin
                e_data[i*8 +: 8] = m_d1[src*8 +: 8];
                e_char[i]        = m_c1[src];
            end else begin
                e_data[i*8 +: 8] = d[(src-4)*8 +: 8];
                e_char[i]        = c[src-4];
            end
        end
        e_valid = (m_mode == 2) && b;
        n = 0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_c1[i] && m_d1[i*8 +: 8] == 8'hBC) begin
                n++;
                k = i;
            end
        end
        if (!b) begin
            drop_to_hunt();
        end else if (m_mode == 0) begin
            if (n == 1) begin
                m_off = k; m_match = 1; m_miss = 0; m_tmo = 0;
                m_mode = (LOCK_CNT <= 1) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (n >= 2) begin
                m_mode = 0; m_match = 0;
            end else if (n == 1 && k == m_off) begin
                m_match++;
                if (m_match == LOCK_CNT) begin
                    m_mode = 2; m_miss = 0; m_tmo = 0;
                end
            end else if (n == 1) begin
                m_off = k; m_match = 1;
            end
        end else begin
            if (n == 1 && k == m_off) begin
                m_miss = 0; m_tmo = 0;
            end else if (n > 0) begin
                m_miss++;
                if (m_miss == LOSS_CNT) drop_to_hunt();
            end else begin
                m_tmo++;
                if (m_tmo == TIMEOUT) drop_to_hunt();
            end
        end
        m_d1 = d;
        m_c1 = c;
    endtask

    task automatic step(input logic r, input logic b, input logic [31:0] d, input logic [3:0] c);
        @(negedge clk);
        rst = r; ba = b; din = d; cin = c;
        @(posedge clk);
        model_edge(r, b, d, c);
        #1;
        prev_d = last_d;
        last_d = d;
        cyc++;
        chk("model.o_data",   o_data,          e_data);
        chk("model.o_char",   32'(o_char),     32'(e_char));
        chk("model.o_valid",  32'(o_valid),    32'(e_valid));
        chk("model.o_locked", 32'(o_locked),   32'(m_mode == 2));
        chk("model.o_offset", 32'(o_offset),   32'(m_off));
        chk("model.o_relock", 32'(o_relock),   32'(m_relock));
    endtask

    function automatic logic [31:0] inc_word(input int j);
        return {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
    endfunction

    initial begin
        logic [31:0] w;
        logic [3:0]  cc;
        int first_lock, first_valid, n_cw, jj, pref, rr, l1, l2;
        logic        rb, rr_rst;

        rst = 1'b1; ba = 1'b0; din = '0; cin = '0;
        prev_d = '0; last_d = '0;

        tbl[0]  = '{1'b1, 1'b1, 32'h44BC2211, 4'b0100, 32'h00000000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'h44BC2211, 4'b0100, 32'h00000000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'h44BC2211, 4'b0100, 32'h44BC2211, 4'b0100, 1'b0, 1'b0, 2'd2, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 32'h44BC2211, 4'b0100, 32'h221144BC, 4'b0001, 1'b0, 1'b0, 2'd2, 16'd0};
        tbl[4]  = '{1'b0, 1'b1, 32'h44BC2211, 4'b0100, 32'h221144BC, 4'b0001, 1'b0, 1'b0, 2'd2, 16'd0};
        tbl[5]  = '{1'b0, 1'b1, 32'h44BC2211, 4'b0100, 32'h221144BC, 4'b0001, 1'b0, 1'b1, 2'd2, 16'd0};
        tbl[6]  = '{1'b0, 1'b1, 32'h44BC2211, 4'b0100, 32'h221144BC, 4'b0001, 1'b1, 1'b1, 2'd2, 16'd0};
        tbl[7]  = '{1'b0, 1'b1, 32'h01020304, 4'b0000, 32'h030444BC, 4'b0001, 1'b1, 1'b1, 2'd2, 16'd0};
        tbl[8]  = '{1'b0, 1'b1, 32'h01020304, 4'b0000, 32'h03040102, 4'b0000, 1'b1, 1'b1, 2'd2, 16'd0};
        tbl[9]  = '{1'b0, 1'b1, 32'hBCBC0000, 4'b1100, 32'h00000102, 4'b0000, 1'b1, 1'b1, 2'd2, 16'd0};
        tbl[10] = '{1'b0, 1'b1, 32'h01020304, 4'b0000, 32'h0304BCBC, 4'b0011, 1'b1, 1'b1, 2'd2, 16'd0};
        tbl[11] = '{1'b0, 1'b0, 32'h01020304, 4'b0000, 32'h03040102, 4'b0000, 1'b0, 1'b0, 2'd2, 16'd1};
        tbl[12] = '{1'b0, 1'b1, 32'h01020304, 4'b0000, 32'h03040102, 4'b0000, 1'b0, 1'b0, 2'd2, 16'd1};

        step(1'b1, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].ba, tbl[i].d, tbl[i].c);
            chk($sformatf("tbl[%0d].o_data", i),   o_data,        tbl[i].x_data);
            chk($sformatf("tbl[%0d].o_char", i),   32'(o_char),   32'(tbl[i].x_char));
            chk($sformatf("tbl[%0d].o_valid", i),  32'(o_valid),  32'(tbl[i].x_valid));
            chk($sformatf("tbl[%0d].o_locked", i), 32'(o_locked), 32'(tbl[i].x_locked));
            chk($sformatf("tbl[%0d].o_offset", i), 32'(o_offset), 32'(tbl[i].x_off));
            chk($sformatf("tbl[%0d].o_relock", i), 32'(o_relock), 32'(tbl[i].x_relock));
        end

        // incrementing stream, comma in lane 2 every 8th word
        step(1'b1, 1'b1, 32'h0, 4'h0);
        first_lock = -1; first_valid = -1; n_cw = 0;
        for (int j = 0; j < 40; j++) begin
            w = inc_word(j); cc = 4'b0000;
            if (j % 8 == 0) begin w[23:16] = 8'hBC; cc = 4'b0100; end
            step(1'b0, 1'b1, w, cc);
            if (o_locked && first_lock < 0) first_lock = j;
            if (o_valid && first_valid < 0) first_valid = j;
            if (o_valid && o_char == 4'b0001) begin
                n_cw++;
                chk("seq1.comma_byte", 32'(o_data[7:0]), 32'hBC);
                chk("seq1.byte2", 32'(o_data[23:16]), 32'(8'(o_data[15:8] + 8'd1)));
                chk("seq1.byte3", 32'(o_data[31:24]), 32'(8'(o_data[23:16] + 8'd1)));
            end
        end
        chk("seq1.lock_step", 32'(first_lock), 32'd25);
        chk("seq1.valid_step", 32'(first_valid), 32'd26);
        chk("seq1.offset", 32'(o_offset), 32'd2);
        chk("seq1.comma_words", 32'(n_cw), 32'd1);

        // commas move to lane 1: lose after three, relock after four more
        jj = 40;
        for (int j = 0; j < 24; j++) begin
            w = inc_word(jj); cc = 4'b0000;
            if (j % 8 == 0) begin w[15:8] = 8'hBC; cc = 4'b0010; end
            step(1'b0, 1'b1, w, cc); jj++;
        end
        chk("seq2.unlocked", 32'(o_locked), 32'd0);
        chk("seq2.relock_cnt", 32'(o_relock), 32'd1);
        for (int j = 0; j < 32; j++) begin
            w = inc_word(jj); cc = 4'b0000;
            if (j % 8 == 0) begin w[15:8] = 8'hBC; cc = 4'b0010; end
            step(1'b0, 1'b1, w, cc); jj++;
        end
        chk("seq2.relocked", 32'(o_locked), 32'd1);
        chk("seq2.offset", 32'(o_offset), 32'd1);

        // comma-free timeout
        w = inc_word(jj); w[15:8] = 8'hBC; jj++;
        step(1'b0, 1'b1, w, 4'b0010);
        for (int j = 0; j < TIMEOUT; j++) begin
            step(1'b0, 1'b1, inc_word(jj), 4'b0000); jj++;
        end
        chk("seq3.still_locked", 32'(o_locked), 32'd1);
        step(1'b0, 1'b1, inc_word(jj), 4'b0000); jj++;
        chk("seq3.timeout_unlock", 32'(o_locked), 32'd0);
        chk("seq3.relock_cnt", 32'(o_relock), 32'd2);
        step(1'b0, 1'b1, inc_word(jj), 4'b0000); jj++;
        chk("seq3.valid_low", 32'(o_valid), 32'd0);

        // double comma in CHECK clears the match count
        step(1'b0, 1'b1, 32'h111111BC, 4'b0001);
        step(1'b0, 1'b1, 32'h222222BC, 4'b0001);
        step(1'b0, 1'b1, 32'h3333BCBC, 4'b0011);
        step(1'b0, 1'b1, 32'h444444BC, 4'b0001);
        step(1'b0, 1'b1, 32'h555555BC, 4'b0001);
        step(1'b0, 1'b1, 32'h666666BC, 4'b0001);
        step(1'b0, 1'b1, 32'h77777777, 4'b0000);
        chk("seq4.not_locked", 32'(o_locked), 32'd0);
        step(1'b0, 1'b1, 32'h888888BC, 4'b0001);
        step(1'b0, 1'b1, 32'h99999999, 4'b0000);
        chk("seq4.locked", 32'(o_locked), 32'd1);
        chk("seq4.offset", 32'(o_offset), 32'd0);

        // offset 0: output is the word from the previous step
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 1'b1, $urandom, 4'b0000);
            chk("seq5.passthru", o_data, prev_d);
        end

        // single-cycle byte-align drop, then reset pulse
        step(1'b0, 1'b0, 32'h12345678, 4'b0000);
        chk("seq6.ba_unlock", 32'(o_locked), 32'd0);
        chk("seq6.relock_cnt", 32'(o_relock), 32'd3);
        step(1'b0, 1'b1, 32'hAAAAAABC, 4'b0001);
        step(1'b1, 1'b1, 32'hBBBBBBBB, 4'b0000);
        chk("seq7.rst_data", o_data, 32'h0);
        chk("seq7.rst_char", 32'(o_char), 32'h0);
        chk("seq7.rst_valid", 32'(o_valid), 32'h0);
        chk("seq7.rst_locked", 32'(o_locked), 32'h0);
        chk("seq7.rst_offset", 32'(o_offset), 32'h0);
        chk("seq7.rst_relock", 32'(o_relock), 32'h0);

        // randomized stream against the reference model
        pref = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 0) pref = $urandom_range(0, 3);
            w  = $urandom;
            cc = 4'b0000;
            if ($urandom_range(0, 9) == 0) begin
                l1 = $urandom_range(0, 3);
                cc[l1] = 1'b1;
            end
            rr = $urandom_range(0, 99);
            if (rr < 20) begin
                w[pref*8 +: 8] = 8'hBC; cc[pref] = 1'b1;
            end else if (rr < 23) begin
                l1 = $urandom_range(0, 3);
                w[l1*8 +: 8] = 8'hBC; cc[l1] = 1'b1;
            end else if (rr < 25) begin
                l1 = $urandom_range(0, 3);
                l2 = (l1 + 1 + $urandom_range(0, 2)) % 4;
                w[l1*8 +: 8] = 8'hBC; cc[l1] = 1'b1;
                w[l2*8 +: 8] = 8'hBC; cc[l2] = 1'b1;
            end
            rb     = ($urandom_range(0, 199) != 0);
            rr_rst = ($urandom_range(0, 999) == 0);
            step(rr_rst, rb, w, cc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
